// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - single-channel TMDS receiver: word alignment by control-run hunting, then symbol decode
module tmds_channel_rx #(
  parameter int SEARCH_WINDOW = 1024,
  parameter int CTRL_RUN      = 8,
  parameter int LOCK_RUNS     = 4,
  parameter int LOSS_WINDOWS  = 2
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic [9:0] raw_sym,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic [3:0] slip
);

  localparam int WW = $clog2(SEARCH_WINDOW);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int VW = $clog2(LOCK_RUNS + 1);
  localparam int LW = $clog2(LOSS_WINDOWS + 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [9:0]    prev;
  logic [9:0]    aligned;
  logic [1:0]    state, state_n;
  logic [RW-1:0] run_cnt, run_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [VW-1:0] vrun_cnt, vrun_n;
  logic [LW-1:0] loss_cnt, loss_n;
  logic [3:0]    slip_n;
  logic          slip_chg;
  logic          is_ctrl;
  logic [1:0]    tok;
  logic          run_event;
  logic          win_expire;
  logic [7:0]    q;
  logic [7:0]    dec;

  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    case (aligned)
      10'b1101010100: tok = 2'b00;
      10'b0010101011: tok = 2'b01;
      10'b0101010100: tok = 2'b10;
      10'b1010101011: tok = 2'b11;
      default:        is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    q      = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec    = 8'd0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++)
      dec[i] = aligned[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  end

  assign run_event  = is_ctrl && (run_cnt == RW'(CTRL_RUN - 1));
  assign win_expire = (win_cnt == WW'(SEARCH_WINDOW - 1));

  // A run event takes priority over a simultaneous window expiry.
  always_comb begin
    state_n  = state;
    slip_n   = slip;
    slip_chg = 1'b0;
    vrun_n   = vrun_cnt;
    loss_n   = loss_cnt;
    win_n    = win_cnt + WW'(1);
    if (!is_ctrl)
      run_n = '0;
    else if (run_cnt == RW'(CTRL_RUN))
      run_n = run_cnt;
    else
      run_n = run_cnt + RW'(1);

    case (state)
      ST_SEARCH: begin
        if (run_event) begin
          state_n = ST_VERIFY;
          vrun_n  = '0;
          win_n   = '0;
        end else if (win_expire) begin
          slip_chg = 1'b1;
        end
      end
      ST_VERIFY: begin
        if (run_event) begin
          win_n = '0;
          if (vrun_cnt == VW'(LOCK_RUNS - 1)) begin
            state_n = ST_LOCKED;
            vrun_n  = '0;
          end else begin
            vrun_n = vrun_cnt + VW'(1);
          end
        end else if (win_expire) begin
          state_n  = ST_SEARCH;
          slip_chg = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (run_event) begin
          loss_n = '0;
          win_n  = '0;
        end else if (win_expire) begin
          win_n = '0;
          if (loss_cnt == LW'(LOSS_WINDOWS - 1)) begin
            state_n = ST_SEARCH;
            loss_n  = '0;
          end else begin
            loss_n = loss_cnt + LW'(1);
          end
        end
      end
      default: begin
        state_n = ST_SEARCH;
        win_n   = '0;
      end
    endcase

    if (slip_chg) begin
      slip_n = (slip == 4'd9) ? 4'd0 : slip + 4'd1;
      run_n  = '0;
      win_n  = '0;
      vrun_n = '0;
      loss_n = '0;
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      aligned  <= '0;
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      vrun_cnt <= '0;
      loss_cnt <= '0;
      slip     <= '0;
      VD       <= '0;
      CD       <= '0;
      VDE      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      prev     <= raw_sym;
      aligned  <= 10'({raw_sym, prev} >> slip);
      state    <= state_n;
      run_cnt  <= run_n;
      win_cnt  <= win_n;
      vrun_cnt <= vrun_n;
      loss_cnt <= loss_n;
      slip     <= slip_n;
      locked   <= (state_n == ST_LOCKED);
      // Outputs follow the post-update state so they move together with locked.
      if (state_n != ST_LOCKED) begin
        VD  <= '0;
        CD  <= '0;
        VDE <= 1'b0;
      end else if (is_ctrl) begin
        VDE <= 1'b0;
        CD  <= tok;
      end else begin
        VDE <= 1'b1;
        VD  <= dec;
      end
    end
  end

endmodule

// File: doc/tmds_channel_rx.md
Name: tmds_channel_rx

Overview:
- Receive side of the single-channel TMDS link produced by the video output path.
- Takes raw 10-bit parallel words from an external deserializer whose word boundary is arbitrary. Finds the correct bit rotation by hunting for runs of control tokens, then decodes each symbol back to 8-bit pixel data, 2-bit control data and a data-enable flag.
- Used for loopback verification of the display pipeline and as the front end of a DVI capture path.

Parameters:
- SEARCH_WINDOW, 1024, symbols allowed between qualifying control runs (greater than one 800-pixel line).
- CTRL_RUN, 8, consecutive control tokens that make a qualifying run.
- LOCK_RUNS, 4, further qualifying runs needed in VERIFY before lock.
- LOSS_WINDOWS, 2, consecutive run-free windows in LOCKED before lock is dropped.

Ports:
- clk_25  in  1  symbol clock, one raw word per rising edge
- reset_n  in  1  asynchronous, active-low reset
- raw_sym  in  10  deserialized word; bit 0 received first
- VD  out  8  decoded video data
- CD  out  2  decoded control data
- VDE  out  1  1 = VD valid (data period), 0 = control period
- locked  out  1  alignment achieved
- slip  out  4  current rotation, 0..9

Behaviour:
- Reset: VD=0, CD=0, VDE=0, locked=0, slip=0, FSM=SEARCH, all counters 0, previous-word register 0. Reset asserted at any time, including while locked, forces these values immediately.
- Alignment:
  - prev <= raw_sym every clock.
  - window = {raw_sym, prev}, 20 bits.
  - aligned <= (window >> slip)[9:0], registered.
- Control token classification on aligned:
  - 1101010100 -> CD 00
  - 0010101011 -> CD 01
  - 0101010100 -> CD 10
  - 1010101011 -> CD 11
  - Anything else is a data symbol.
- Run counter:
  - Increments on each control token and saturates at CTRL_RUN.
  - Clears on a data symbol.
  - A qualifying run event fires once, on the cycle the count reaches CTRL_RUN.
- Window counter:
  - Counts symbols since the last run event or since entering a state.
  - Clears on a run event.
  - Expires at SEARCH_WINDOW-1.
- Slip increment: slip = (slip==9) ? 0 : slip+1. The counters (run, window, VERIFY run count, LOSS count) clear on every slip change.
- FSM:
  - SEARCH: run event -> VERIFY with run count 0. Window expiry -> slip increment, stay in SEARCH.
  - VERIFY: each run event increments the run count; when it reaches LOCK_RUNS -> LOCKED. Window expiry -> slip increment, SEARCH.
  - LOCKED: a run event clears the loss count. Window expiry increments the loss count; when it reaches LOSS_WINDOWS -> SEARCH with slip held (not incremented).
  - If a run event and window expiry occur in the same cycle, the run event wins.
- Decode, from aligned d:
  - q = d[9] ? ~d[7:0] : d[7:0].
  - out[0] = q[0].
  - out[i] = d[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), for i = 1..7.
- Outputs are registered.
  - Latency: the raw_sym that completes a symbol is reflected on the outputs 2 clocks later.
  - locked=0: VD=0, VDE=0, CD=0.
  - Locked control symbol: VDE=0, CD=token value, VD holds its last value.
  - Locked data symbol: VDE=1, VD=decoded value, CD holds its last value.
- locked = (FSM==LOCKED), registered so that it changes in the same cycle as the other outputs.
- slip output equals the internal rotation register.

Test Plan:
- Aligned stream: 100 data symbols, then 20 tokens 1101010100, repeated every 800 symbols -> locked=1 after the 5th run (1 SEARCH + LOCK_RUNS), slip=0; CD=00, VDE=0 during the tokens.
- Same stream delivered pre-rotated by 3 bits -> slip steps 0,1,2,3 at SEARCH_WINDOW intervals; lock at slip=3; decoded values match the source.
- Data decode while locked:
  - aligned 0100000000 -> VD=0x00, VDE=1.
  - aligned 1011111111 -> VD=0xFE, VDE=1.
  - Outputs appear exactly 2 clocks after the completing raw_sym.
- Control decode while locked: 0010101011, 0101010100, 1010101011 -> CD = 01, 10, 11 respectively; VD holds its prior value.
- Loss: while locked, send only data symbols for 2*SEARCH_WINDOW -> locked falls at the second expiry; slip is unchanged; FSM re-enters SEARCH; outputs are zeroed.
- Reset mid-lock: pull reset_n low asynchronously between edges -> VD, CD, VDE, locked and slip go to 0 immediately; after release, lock is reacquired as in the first scenario.
